hw_accel_frame_ctrl: RTL and testbench
======================================

HW_ACCEL_FRAME_CTRL -- requirements
Module: hw_accel_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 540, meaning input pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 540, meaning input lines per frame.
REQ-003 SHALL have parameter OUT_WORDS, default 27648, meaning packed 32-bit words expected per frame (192x192 RGB888 divided by 4 bytes).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the drain watchdog limit in clk cycles.
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, a single-cycle pulse that arms one frame capture.
REQ-008 SHALL have port abort, input, 1, a level that cancels the current capture.
REQ-009 SHALL have port frame_sof, input, 1, a camera start-of-frame pulse.
REQ-010 SHALL have port in_pixel_valid, input, 1, the camera pixel strobe.
REQ-011 SHALL have port accel_out_valid, input, 1, the packed-word strobe from the pack stage.
REQ-012 SHALL have port accel_pixel_valid, output, 1, the gated strobe into the downscaler.
REQ-013 SHALL have port accel_rst, output, 1, an active-high flush driven to the downscale/pack datapath.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, a single-cycle frame-complete pulse.
REQ-016 SHALL have port error, output, 1, a sticky error flag.
REQ-017 SHALL have port out_word_cnt, output, 16, the count of packed words received in the current frame.

Function
REQ-018 SHALL implement states IDLE, FLUSH, WAIT_SOF, STREAM, DRAIN, DONE and ERROR.
REQ-019 IDLE: start SHALL move to FLUSH, clear error and out_word_cnt, and zero the pixel counter.
REQ-020 FLUSH: accel_rst SHALL be held high for exactly 2 cycles, then the FSM SHALL move to WAIT_SOF.
REQ-021 WAIT_SOF: accel_pixel_valid SHALL be 0; frame_sof SHALL move to STREAM, and in_pixel_valid coincident with frame_sof SHALL be passed through and counted.
REQ-022 STREAM: accel_pixel_valid SHALL equal in_pixel_valid combinationally (0-cycle latency); each valid SHALL increment the pixel counter.
REQ-023 STREAM: a valid on pixel FRAME_WIDTH*FRAME_HEIGHT-1 SHALL move to DRAIN in the next cycle, and accel_pixel_valid SHALL be 0 from then on.
REQ-024 STREAM: frame_sof before the frame is complete (short frame) SHALL move to ERROR; frame_sof coincident with the final pixel SHALL be ignored.
REQ-025 In STREAM and DRAIN, each accel_out_valid SHALL increment out_word_cnt, saturating at OUT_WORDS; words arriving outside these states SHALL be ignored.
REQ-026 DRAIN: when out_word_cnt reaches OUT_WORDS (including via a coincident accel_out_valid), the FSM SHALL move to DONE.
REQ-027 DONE: done SHALL be high for 1 cycle, then the FSM SHALL move to IDLE; out_word_cnt SHALL be held until the next start.
REQ-028 ERROR: error SHALL be set and accel_rst held high; start SHALL move to FLUSH and clear error.
REQ-029 abort SHALL take priority over every other event, force IDLE with accel_rst high for that cycle, and SHALL NOT set error.
REQ-030 start SHALL be ignored in every state other than IDLE and ERROR.

Reset
REQ-031 On rst_n low, the state SHALL be IDLE and the outputs SHALL be: accel_pixel_valid=0, accel_rst=1, busy=0, done=0, error=0, out_word_cnt=0.
REQ-032 Reset release SHALL be synchronous-deasserted internally, and accel_rst SHALL drop on the first clk edge after release.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no done pulse.

Configuration
REQ-034 Macro HW_ACCEL_TIMEOUT_EN defined: in DRAIN, a watchdog SHALL count cycles since the last accel_out_valid, reload on each word, and move to ERROR when it reaches TIMEOUT_CYCLES.
REQ-035 Macro HW_ACCEL_TIMEOUT_EN undefined: no watchdog logic SHALL be present, DRAIN SHALL wait indefinitely, and only a short frame SHALL cause ERROR.

Verification (FRAME_WIDTH=8, FRAME_HEIGHT=8, OUT_WORDS=12, TIMEOUT_CYCLES=16)
REQ-036 Nominal: start, then frame_sof, 64 pixels, and 12 out words -> accel_rst high for 2 cycles, 64 gated valids, done pulse once, out_word_cnt=12, error=0.
REQ-037 Short frame: frame_sof again after 40 pixels -> ERROR, error=1, accel_rst=1, and no done.
REQ-038 Timeout (macro defined): 64 pixels and only 5 words, then silence -> error=1 exactly 16 cycles after the 5th word; with the macro undefined, busy stays 1.
REQ-039 Abort: abort asserted at pixel 30 -> IDLE next cycle, busy=0, error=0; a subsequent start/frame completes normally.
REQ-040 Gating and extras: pixels before frame_sof and after pixel 64, plus a 13th word -> none forwarded, out_word_cnt stays 12, and start during STREAM is ignored.
REQ-041 Reset mid-DRAIN: rst_n pulled low -> all outputs at reset values immediately and no done pulse.

Source files
------------

// File: rtl/hw_accel_frame_ctrl.sv
// Frame capture controller: flushes the downscale/pack datapath, gates one camera
// frame into it and waits for the packed words. Define HW_ACCEL_TIMEOUT_EN for the drain watchdog.
module hw_accel_frame_ctrl #(
  parameter int unsigned FRAME_WIDTH    = 540,
  parameter int unsigned FRAME_HEIGHT   = 540,
  parameter int unsigned OUT_WORDS      = 27648,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        frame_sof,
  input  logic        in_pixel_valid,
  input  logic        accel_out_valid,
  output logic        accel_pixel_valid,
  output logic        accel_rst,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] out_word_cnt
);

  localparam int unsigned FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int unsigned PIX_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [15:0]      WORD_LIMIT = 16'(OUT_WORDS);

  typedef enum logic [2:0] {
    IDLE, FLUSH, WAIT_SOF, STREAM, DRAIN, DONE, ERROR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              rst_sync;
  logic              flush_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic              kill;
  logic              arm;
  logic              pix_take;
  logic              last_pix;
  logic              word_take;
  logic [15:0]       cnt_next;
  logic              wd_expired;

  // Reset release is seen by the FSM one edge late; until then it behaves as an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 1'b0;
      state    <= IDLE;
    end else begin
      rst_sync <= 1'b1;
      state    <= state_next;
    end
  end

  always_comb begin
    kill      = abort || !rst_sync;
    arm       = !kill && start && (state == IDLE || state == ERROR);
    pix_take  = !kill && in_pixel_valid &&
                (state == STREAM || (state == WAIT_SOF && frame_sof));
    last_pix  = pix_take && (pix_cnt == LAST_PIX);
    word_take = !kill && accel_out_valid && (state == STREAM || state == DRAIN) &&
                (out_word_cnt < WORD_LIMIT);
    cnt_next  = word_take ? out_word_cnt + 16'd1 : out_word_cnt;
  end

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:     if (start) state_next = FLUSH;
        FLUSH:    if (flush_cnt) state_next = WAIT_SOF;
        WAIT_SOF: if (frame_sof) state_next = last_pix ? DRAIN : STREAM;
        STREAM: begin
          // The final pixel wins over a coincident frame_sof.
          if (last_pix)       state_next = DRAIN;
          else if (frame_sof) state_next = ERROR;
        end
        DRAIN: begin
          if (cnt_next == WORD_LIMIT) state_next = DONE;
          else if (wd_expired)        state_next = ERROR;
        end
        DONE:     state_next = IDLE;
        ERROR:    if (start) state_next = FLUSH;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy              = (state != IDLE);
    done              = (state == DONE) && !kill;
    accel_rst         = kill || (state == FLUSH) || (state == ERROR);
    accel_pixel_valid = pix_take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt    <= 1'b0;
      pix_cnt      <= '0;
      out_word_cnt <= '0;
      error        <= 1'b0;
    end else begin
      flush_cnt <= (state == FLUSH);
      if (arm) begin
        pix_cnt      <= '0;
        out_word_cnt <= '0;
        error        <= 1'b0;
      end else begin
        if (pix_take) pix_cnt <= pix_cnt + PIX_W'(1);
        out_word_cnt <= cnt_next;
        if (state_next == ERROR) error <= 1'b1;
      end
    end
  end

`ifdef HW_ACCEL_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Holds the number of cycles since the last word (or drain entry) including the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            wd_cnt <= WD_W'(1);
    else if (state != DRAIN || accel_out_valid) wd_cnt <= WD_W'(1);
    else                                   wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_expired = (state == DRAIN) && !accel_out_valid && (wd_cnt == WD_LAST);
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_hw_accel_frame_ctrl.sv
// Self-checking bench for hw_accel_frame_ctrl with an 8x8 frame, 12 words, 16-cycle watchdog.
module tb_hw_accel_frame_ctrl;

  localparam int NPIX = 64;
  localparam int OW   = 12;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        frame_sof = 1'b0;
  logic        in_pixel_valid = 1'b0;
  logic        accel_out_valid = 1'b0;
  logic        accel_pixel_valid;
  logic        accel_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] out_word_cnt;

  hw_accel_frame_ctrl #(
    .FRAME_WIDTH(8), .FRAME_HEIGHT(8), .OUT_WORDS(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_sof(frame_sof),
    .in_pixel_valid(in_pixel_valid), .accel_out_valid(accel_out_valid),
    .accel_pixel_valid(accel_pixel_valid), .accel_rst(accel_rst), .busy(busy),
    .done(done), .error(error), .out_word_cnt(out_word_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: capture phase plus plain counters of pixels and words taken.
  typedef enum int {M_IDLE, M_FLUSH, M_SOF, M_PIX, M_TAIL, M_FIN, M_ERR} mph_t;
  mph_t mph = M_IDLE;
  int   m_flush_left = 0;
  int   m_pix = 0;
  int   m_words = 0;
  int   m_quiet = 0;
  bit   m_err = 1'b0;
  bit   m_rel = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mph = M_IDLE; m_pix = 0; m_words = 0; m_err = 1'b0; m_rel = 1'b0; m_quiet = 0;
    end else begin
      bit gone;
      gone = abort || !m_rel;
      if (!gone && in_pixel_valid && (mph == M_PIX || (mph == M_SOF && frame_sof))) m_pix++;
      if (!gone && accel_out_valid && (mph == M_PIX || mph == M_TAIL) && m_words < OW) m_words++;
      if (gone) mph = M_IDLE;
      else case (mph)
        M_IDLE, M_ERR:
          if (start) begin
            mph = M_FLUSH; m_flush_left = 2; m_pix = 0; m_words = 0; m_err = 1'b0;
          end
        M_FLUSH: begin
          m_flush_left--;
          if (m_flush_left == 0) mph = M_SOF;
        end
        M_SOF: if (frame_sof) mph = (m_pix == NPIX) ? M_TAIL : M_PIX;
        M_PIX:
          if (m_pix == NPIX) mph = M_TAIL;
          else if (frame_sof) begin mph = M_ERR; m_err = 1'b1; end
        M_TAIL:
          if (m_words == OW) mph = M_FIN;
`ifdef HW_ACCEL_TIMEOUT_EN
          else begin
            m_quiet = accel_out_valid ? 0 : m_quiet + 1;
            if (m_quiet == TO - 1) begin mph = M_ERR; m_err = 1'b1; end
          end
`endif
        M_FIN: mph = M_IDLE;
        default: mph = M_IDLE;
      endcase
      if (mph != M_TAIL) m_quiet = 0;
      m_rel = 1'b1;
    end
  end

  int nerr = 0;
  int nchk = 0;
  int apv_cnt = 0;
  int done_cnt = 0;
  int arst_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic e_apv, e_arst, e_busy, e_done;
    e_apv  = m_rel && !abort && in_pixel_valid && (mph == M_PIX || (mph == M_SOF && frame_sof));
    e_arst = !m_rel || abort || mph == M_FLUSH || mph == M_ERR;
    e_busy = (mph != M_IDLE);
    e_done = m_rel && !abort && mph == M_FIN;
    chk("accel_pixel_valid", 32'(accel_pixel_valid), 32'(e_apv));
    chk("accel_rst", 32'(accel_rst), 32'(e_arst));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(m_err));
    chk("out_word_cnt", 32'(out_word_cnt), 32'(m_words));
  endtask

  // One cycle: check mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    apv_cnt  += int'(accel_pixel_valid);
    done_cnt += int'(done);
    arst_cnt += int'(accel_rst);
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) begin in_pixel_valid = 1'($urandom_range(1, 0)); tick(); end
    in_pixel_valid = 1'b0;
  endtask

  task automatic feed(input int npix, input int nw, input int start_at, output int wsent);
    int got;
    int k;
    wsent = 0; k = 0;
    frame_sof = 1'b1; in_pixel_valid = 1'b1; tick(); got = 1;
    frame_sof = 1'b0;
    while (got < npix) begin
      in_pixel_valid  = ($urandom_range(3, 0) != 0);
      accel_out_valid = (wsent < nw) && (k % 2 == 0);
      start           = (got == start_at);
      if (accel_out_valid) wsent++;
      if (in_pixel_valid) got++;
      k++;
      tick();
    end
    in_pixel_valid = 1'b0; accel_out_valid = 1'b0; start = 1'b0;
  endtask

  task automatic drain_words(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      accel_out_valid = 1'b1; tick(); accel_out_valid = 1'b0;
    end
  endtask

  task automatic full_frame();
    int ws;
    feed(NPIX, $urandom_range(OW, 0), -1, ws);
    drain_words(OW - ws, 5);
    repeat (3) tick();
  endtask

  initial begin
    int ws, a0, d0, r0, kind;

    repeat (3) tick();
    chk("rst_accel_rst", 32'(accel_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(out_word_cnt), 0);
    rst_n = 1'b1;
    chk("release_accel_rst_held", 32'(accel_rst), 1);
    tick();
    chk("release_accel_rst_drop", 32'(accel_rst), 0);

    // Nominal frame with junk pixels, a start during streaming and a 13th word.
    a0 = apv_cnt; d0 = done_cnt; r0 = arst_cnt;
    arm();
    chk("nom_flush_cycles", 32'(arst_cnt - r0), 2);
    feed(NPIX, 4, 20, ws);
    repeat (3) begin in_pixel_valid = 1'b1; tick(); end
    in_pixel_valid = 1'b0;
    drain_words(OW - ws, 3);
    accel_out_valid = 1'b1; tick(); accel_out_valid = 1'b0;
    repeat (3) tick();
    chk("nom_gated_valids", 32'(apv_cnt - a0), 64);
    chk("nom_done_pulses", 32'(done_cnt - d0), 1);
    chk("nom_word_cnt", 32'(out_word_cnt), 12);
    chk("nom_error", 32'(error), 0);

    // Word saturation inside the stream.
    d0 = done_cnt;
    arm(); feed(NPIX, 14, -1, ws); repeat (3) tick();
    chk("sat_word_cnt", 32'(out_word_cnt), 12);
    chk("sat_done_pulses", 32'(done_cnt - d0), 1);

    // Short frame, then restart from the error state.
    d0 = done_cnt;
    arm(); feed(40, 2, -1, ws);
    frame_sof = 1'b1; tick(); frame_sof = 1'b0;
    chk("short_error", 32'(error), 1);
    chk("short_accel_rst", 32'(accel_rst), 1);
    repeat (3) tick();
    chk("short_no_done", 32'(done_cnt - d0), 0);
    d0 = done_cnt;
    arm();
    chk("restart_error_clear", 32'(error), 0);
    full_frame();
    chk("restart_done", 32'(done_cnt - d0), 1);

    // Abort mid-stream.
    arm(); feed(30, 3, -1, ws);
    abort = 1'b1; in_pixel_valid = 1'b1; tick(); abort = 1'b0; in_pixel_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_error", 32'(error), 0);
    d0 = done_cnt;
    arm(); full_frame();
    chk("after_abort_done", 32'(done_cnt - d0), 1);

    // Drain stalls after five words.
    arm(); feed(NPIX, 0, -1, ws);
    drain_words(5, 3);
`ifdef HW_ACCEL_TIMEOUT_EN
    repeat (14) tick();
    chk("timeout_not_yet", 32'(error), 0);
    tick();
    chk("timeout_error", 32'(error), 1);
    tick();
`else
    repeat (40) tick();
    chk("stall_busy", 32'(busy), 1);
    chk("stall_error", 32'(error), 0);
`endif
    abort = 1'b1; tick(); abort = 1'b0; tick();

    // Reset during drain.
    d0 = done_cnt;
    arm(); feed(NPIX, 0, -1, ws); drain_words(3, 2);
    rst_n = 1'b0; #1;
    chk("mid_rst_accel_rst", 32'(accel_rst), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_cnt", 32'(out_word_cnt), 0);
    chk("mid_rst_apv", 32'(accel_pixel_valid), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_no_done", 32'(done_cnt - d0), 0);

    // Randomised frames: complete, short, or aborted.
    for (int r = 0; r < 10; r++) begin
      kind = $urandom_range(2, 0);
      arm();
      if (kind == 0) full_frame();
      else if (kind == 1) begin
        feed($urandom_range(NPIX - 2, 1), $urandom_range(OW, 0), -1, ws);
        frame_sof = 1'b1; tick(); frame_sof = 1'b0; repeat (2) tick();
      end else begin
        feed($urandom_range(NPIX - 1, 1), $urandom_range(OW, 0), 10, ws);
        abort = 1'b1; tick(); abort = 1'b0; tick();
      end
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
